// File: rtl/keypad_pkg.sv
// Shared keypad types: key codes, emulator states, row/column extraction and
// the bounce LFSR taps (8,6,5,4), which any future scanner self-test can reuse.
package keypad_pkg;

  typedef logic [3:0] key_code_t;

  typedef enum logic [2:0] {
    IDLE,
    BOUNCE_P,
    HOLD,
    BOUNCE_R,
    GAP
  } emu_state_t;

  // Feedback mask for a left-shifting Fibonacci register: taps 8,6,5,4 -> bits 7,5,4,3
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [1:0] KEY_ROW(key_code_t code);
    return code[3:2];
  endfunction

  function automatic logic [1:0] KEY_COL(key_code_t code);
    return code[1:0];
  endfunction

endpackage

// File: rtl/bounce_lfsr.sv
// 8-bit Fibonacci LFSR for contact bounce; advances one step per enabled cycle,
// output is bit 0 of the current state. No backpressure.
module bounce_lfsr
  import keypad_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic clock,
  input  logic reset,
  input  logic en,
  output logic bit0
);

  logic [7:0] q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q <= SEED;
    end else if (en) begin
      q <= {q[6:0], ^(q & LFSR_TAPS)};
    end
  end

  assign bit0 = q[0];

endmodule

// File: rtl/hex_keypad_emulator.sv
// 4x4 keypad model: plays each accepted press as bounce/hold/bounce/gap; Row is
// combinational from Col. Requests accepted only in IDLE (req_ready), never queued.
module hex_keypad_emulator
  import keypad_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES   = 40,
  parameter int unsigned BOUNCE_CYCLES = 8,
  parameter int unsigned GAP_CYCLES    = 16,
  parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_valid,
  input  logic [3:0] req_code,
  output logic       req_ready,
  input  logic [3:0] Col,
  output logic [3:0] Row,
  output logic       busy,
  output logic       done
);

  localparam bit          NO_BOUNCE = (BOUNCE_CYCLES == 0);
  localparam logic [15:0] HOLD_LD   = 16'(HOLD_CYCLES - 1);
  localparam logic [15:0] BOUNCE_LD = 16'(BOUNCE_CYCLES - 1);
  localparam logic [15:0] GAP_LD    = 16'(GAP_CYCLES - 1);

  emu_state_t  state;
  logic [15:0] cnt;
  key_code_t   code;
  logic        lfsr_en;
  logic        lfsr_bit;
  logic        contact;

  assign lfsr_en = (state == BOUNCE_P) || (state == BOUNCE_R);

  bounce_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clock(clock),
    .reset(reset),
    .en   (lfsr_en),
    .bit0 (lfsr_bit)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      code  <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      // Each timed state runs N cycles: loaded with N-1, exits on the zero cycle
      if (state != IDLE && cnt != 16'd0) begin
        cnt <= cnt - 16'd1;
      end else begin
        case (state)
          IDLE: begin
            if (req_valid) begin
              code <= req_code;
              if (NO_BOUNCE) begin
                state <= HOLD;
                cnt   <= HOLD_LD;
              end else begin
                state <= BOUNCE_P;
                cnt   <= BOUNCE_LD;
              end
            end
          end
          BOUNCE_P: begin
            state <= HOLD;
            cnt   <= HOLD_LD;
          end
          HOLD: begin
            if (NO_BOUNCE) begin
              state <= GAP;
              cnt   <= GAP_LD;
            end else begin
              state <= BOUNCE_R;
              cnt   <= BOUNCE_LD;
            end
          end
          BOUNCE_R: begin
            state <= GAP;
            cnt   <= GAP_LD;
          end
          GAP: begin
            state <= IDLE;
            done  <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign contact   = (state == HOLD) || (lfsr_en && lfsr_bit);
  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  always_comb begin
    Row = '0;
    if (contact && Col[KEY_COL(code)]) begin
      Row[KEY_ROW(code)] = 1'b1;
    end
  end

endmodule

// File: tb/tb_hex_keypad_emulator.sv
// Bench: two emulators (bouncy and clean) against a press-timeline model.
module tb_hex_keypad_emulator;

  localparam int H = 40;
  localparam int G = 16;

  logic       clock = 1'b0;
  logic       reset;
  logic       rv   [2];
  logic [3:0] rc   [2];
  logic [3:0] col  [2] = '{4'hF, 4'hF};
  logic [3:0] row  [2];
  logic       rdy  [2];
  logic       busy [2];
  logic       done [2];

  int         cmode [2];
  logic [3:0] cfix  [2];

  int nchecks = 0;
  int nerrors = 0;

  bit seq [255];

  bit         m_act  [2];
  int         m_k    [2];
  logic [3:0] m_code [2];
  int         m_bidx [2];
  bit         m_done [2];

  always #5 clock = ~clock;

  hex_keypad_emulator #(.HOLD_CYCLES(H), .BOUNCE_CYCLES(8), .GAP_CYCLES(G), .LFSR_SEED(8'hA5)) dut (
    .clock(clock), .reset(reset), .req_valid(rv[0]), .req_code(rc[0]), .req_ready(rdy[0]),
    .Col(col[0]), .Row(row[0]), .busy(busy[0]), .done(done[0])
  );

  hex_keypad_emulator #(.HOLD_CYCLES(H), .BOUNCE_CYCLES(0), .GAP_CYCLES(G), .LFSR_SEED(8'hA5)) dut_clean (
    .clock(clock), .reset(reset), .req_valid(rv[1]), .req_code(rc[1]), .req_ready(rdy[1]),
    .Col(col[1]), .Row(row[1]), .busy(busy[1]), .done(done[1])
  );

  function automatic int bcyc(int i);
    return (i == 0) ? 8 : 0;
  endfunction

  function automatic int total(int i);
    return 2 * bcyc(i) + H + G;
  endfunction

  function automatic bit in_bounce(int i, int k);
    int b = bcyc(i);
    return (k >= 1 && k <= b) || (k > b + H && k <= 2 * b + H);
  endfunction

  function automatic bit in_hold(int i, int k);
    int b = bcyc(i);
    return (k > b) && (k <= b + H);
  endfunction

  function automatic logic [3:0] exp_row(int i);
    bit c;
    c = m_act[i] && (in_hold(i, m_k[i]) || (in_bounce(i, m_k[i]) && seq[m_bidx[i] % 255]));
    if (c && col[i][m_code[i][1:0]]) return 4'b0001 << m_code[i][3:2];
    return 4'b0000;
  endfunction

  task automatic check(string nm, logic [7:0] act, logic [7:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(string nm);
    nchecks++;
    nerrors++;
    $display("FAIL %s: timed out at %0t", nm, $time);
  endtask

  // Press timeline model: k counts cycles since acceptance (1..total)
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        m_act[i] = 0; m_k[i] = 0; m_code[i] = 0; m_bidx[i] = 0; m_done[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (m_act[i]) begin
          if (in_bounce(i, m_k[i])) m_bidx[i]++;
          if (m_k[i] == total(i)) begin
            m_act[i] = 0; m_done[i] = 1;
          end else begin
            m_k[i]++; m_done[i] = 0;
          end
        end else begin
          m_done[i] = 0;
          if (rv[i]) begin
            m_act[i] = 1; m_k[i] = 1; m_code[i] = rc[i];
          end
        end
      end
    end
  end

  always @(negedge clock) begin
    for (int i = 0; i < 2; i++) begin
      check($sformatf("row%0d", i), {4'h0, row[i]}, {4'h0, exp_row(i)});
      check($sformatf("ready%0d", i), {7'h0, rdy[i]}, {7'h0, !m_act[i]});
      check($sformatf("busy%0d", i), {7'h0, busy[i]}, {7'h0, m_act[i]});
      check($sformatf("done%0d", i), {7'h0, done[i]}, {7'h0, m_done[i]});
    end
  end

  always @(posedge clock) begin
    #1;
    for (int i = 0; i < 2; i++) begin
      case (cmode[i])
        0:       col[i] = cfix[i];
        1:       col[i] = 4'b0001 << $urandom_range(0, 3);
        default: col[i] = 4'($urandom);
      endcase
    end
  end

  task automatic send(int i, logic [3:0] code, bit keep);
    int w = 0;
    @(posedge clock); #1;
    rv[i] = 1'b1;
    rc[i] = code;
    while (w < 500) begin
      @(negedge clock);
      if (rdy[i]) break;
      w++;
    end
    if (w >= 500) timeout("send");
    @(posedge clock); #1;
    if (!keep) rv[i] = 1'b0;
  endtask

  task automatic wait_idle(int i);
    int w = 0;
    while (w < 500) begin
      @(negedge clock);
      if (!busy[i]) break;
      w++;
    end
    if (w >= 500) timeout("wait_idle");
  endtask

  task automatic capture_bounce(string nm);
    logic [7:0] pat;
    send(0, 4'h0, 0);
    for (int j = 0; j < 8; j++) begin
      @(negedge clock);
      pat[j] = row[0][0];
    end
    check(nm, pat, 8'hE5);
    @(negedge clock);
    check({nm, "_hold"}, {4'h0, row[0]}, 8'h01);
    wait_idle(0);
  endtask

  initial begin
    logic [7:0] q;
    logic [7:0] pin;
    int cnt, n, lowcnt, w;

    q = 8'hA5;
    for (int k = 0; k < 255; k++) begin
      seq[k] = q[0];
      q = {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
    end
    for (int j = 0; j < 8; j++) pin[j] = seq[j];
    check("model_seq", pin, 8'hE5);

    cmode = '{0, 0};
    cfix  = '{4'hF, 4'hF};
    rv    = '{1'b0, 1'b0};
    rc    = '{4'h0, 4'h0};
    reset = 1'b1;
    #1 reset = 1'b0;

    repeat (3) begin
      @(negedge clock);
      for (int i = 0; i < 2; i++) begin
        check("rst_row", {4'h0, row[i]}, 8'h00);
        check("rst_ready", {7'h0, rdy[i]}, 8'h01);
        check("rst_busy", {7'h0, busy[i]}, 8'h00);
      end
    end
    @(posedge clock); #1 reset = 1'b1;
    repeat (4) @(negedge clock);
    check("idle_after_rst", {7'h0, busy[0]}, 8'h00);

    // Bounce pattern, then the same pattern again after a fresh reset
    cfix[0] = 4'h1;
    capture_bounce("bounce_pat");
    @(posedge clock); #1 reset = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    capture_bounce("bounce_repeat");

    // Clean edges: code 6 on column 2 gives Row[1] for exactly HOLD cycles
    cfix[1] = 4'h4;
    send(1, 4'h6, 0);
    cnt = 0;
    w = 0;
    while (w < 500) begin
      @(negedge clock);
      if (!busy[1]) break;
      if (row[1] == 4'b0010) cnt++;
      w++;
    end
    if (w >= 500) timeout("clean_press");
    check("clean_hold_cnt", 8'(cnt), 8'd40);
    check("clean_done", {7'h0, done[1]}, 8'h01);

    cmode[1] = 1;
    send(1, 4'h6, 0);
    wait_idle(1);
    cmode[1] = 0;

    // Back-to-back: valid held high, second request taken on the done cycle
    cfix[0] = 4'hF;
    send(0, 4'h3, 1);
    rc[0] = 4'hC;
    n = 0;
    lowcnt = 0;
    while (n < 500) begin
      @(negedge clock);
      n++;
      if (done[0]) break;
      if (!busy[0]) lowcnt++;
    end
    check("b2b_cycles", 8'(n), 8'd73);
    check("b2b_busy_low", 8'(lowcnt), 8'd0);
    check("b2b_ready", {7'h0, rdy[0]}, 8'h01);
    @(negedge clock);
    check("b2b_second", {7'h0, busy[0]}, 8'h01);
    @(posedge clock); #1 rv[0] = 1'b0;
    wait_idle(0);

    // Multi-hot column drive on code B
    send(0, 4'hB, 0);
    repeat (13) @(negedge clock);
    check("multihot_row", {4'h0, row[0]}, 8'h04);
    cfix[0] = 4'h0;
    @(negedge clock);
    check("nocol_row", {4'h0, row[0]}, 8'h00);
    wait_idle(0);
    cfix[0] = 4'hF;

    // Reset during the 20th HOLD cycle
    send(0, 4'h5, 0);
    repeat (28) @(negedge clock);
    check("pre_rst_row", {4'h0, row[0]}, 8'h02);
    #2 reset = 1'b0;
    #1;
    check("async_rst_row", {4'h0, row[0]}, 8'h00);
    check("async_rst_busy", {7'h0, busy[0]}, 8'h00);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    cnt = 0;
    repeat (10) begin
      @(negedge clock);
      if (done[0]) cnt++;
    end
    check("no_done_after_rst", 8'(cnt), 8'd0);
    send(0, 4'h9, 0);
    wait_idle(0);
    check("post_rst_done", {7'h0, done[0]}, 8'h01);

    // Random presses on both emulators with arbitrary column drive
    cmode = '{2, 2};
    fork
      for (int r = 0; r < 20; r++) begin
        repeat ($urandom_range(0, 5)) @(posedge clock);
        send(0, 4'($urandom), 0);
        wait_idle(0);
      end
      for (int r = 0; r < 20; r++) begin
        repeat ($urandom_range(0, 5)) @(posedge clock);
        send(1, 4'($urandom), 0);
        wait_idle(1);
      end
    join

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
